// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the shift/add multiply and restoring divide controller.
// Holds the FSM state encoding, the op codes and the step-counter width helper.
package mult_div_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Bits needed to hold WIDTH-1 (at least one bit).
  function automatic int step_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_div_ctrl_step_counter.sv
// Loadable down-counter that paces the iterative RUN phase.
// zero is a plain decode of the count register.
module step_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequencer for an external multiply/divide datapath: emits load, clear and
// step strobes and reports busy/done/div0 status.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic op,
  input  logic abort,
  input  logic mplier_lsb,
  input  logic rem_neg,
  input  logic divisor_zero,
  output logic op_load,
  output logic acc_clear,
  output logic shift,
  output logic add_en,
  output logic sub_en,
  output logic restore,
  output logic hi_load,
  output logic lo_load,
  output logic busy,
  output logic done,
  output logic div0
);

  localparam int CW = step_cnt_width(WIDTH);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_next;
  logic          op_q;
  logic          div0_pend;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_MULT;
      div0_pend <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start && !abort) begin
        op_q <= op;
      end
      // Remembered from INIT so DONE can flag the zero divisor.
      if (state == ST_INIT) begin
        div0_pend <= (op_q == OP_DIV) && divisor_zero && !abort;
      end else if (state == ST_IDLE || state == ST_DONE) begin
        div0_pend <= 1'b0;
      end
    end
  end

  step_counter #(.CW(CW)) u_step_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (LOAD_VAL),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_next = state;
    op_load    = 1'b0;
    acc_clear  = 1'b0;
    shift      = 1'b0;
    add_en     = 1'b0;
    sub_en     = 1'b0;
    restore    = 1'b0;
    hi_load    = 1'b0;
    lo_load    = 1'b0;
    done       = 1'b0;
    div0       = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    busy       = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (start && !abort) state_next = ST_INIT;
      end
      ST_INIT: begin
        op_load   = 1'b1;
        acc_clear = 1'b1;
        cnt_load  = 1'b1;
        if (abort)                                 state_next = ST_IDLE;
        else if (op_q == OP_DIV && divisor_zero)   state_next = ST_DONE;
        else                                       state_next = ST_RUN;
      end
      ST_RUN: begin
        // add_en and restore follow the live datapath flags within RUN.
        shift   = 1'b1;
        cnt_dec = 1'b1;
        add_en  = (op_q == OP_MULT) && mplier_lsb;
        sub_en  = (op_q == OP_DIV);
        restore = (op_q == OP_DIV) && rem_neg;
        if (abort)         state_next = ST_IDLE;
        else if (cnt_zero) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        hi_load    = 1'b1;
        lo_load    = 1'b1;
        state_next = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        div0       = div0_pend;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: latency, strobe pattern, abort, reset and
// back-to-back scenarios with hand-derived expectations.
module tb_mult_div_ctrl;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic op = 1'b0;
  logic abort = 1'b0;
  logic mplier_lsb = 1'b0;
  logic rem_neg = 1'b0;
  logic divisor_zero = 1'b0;
  logic op_load, acc_clear, shift, add_en, sub_en, restore;
  logic hi_load, lo_load, busy, done, div0;
  logic [10:0] outs;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int k = 0;

  // Per-operation statistics, cleared by the monitor when INIT is seen.
  int n_init = 0;
  int n_shift = 0;
  int n_sub = 0;
  int n_hi = 0;
  int n_lo = 0;
  int n_done = 0;
  int n_div0 = 0;
  int n_restore = 0;
  int n_rmis = 0;
  int n_rbad = 0;
  int done_cyc = 0;
  int hi_cyc = 0;
  logic [31:0] add_mask = '0;

  assign outs = {op_load, acc_clear, shift, add_en, sub_en, restore,
                 hi_load, lo_load, busy, done, div0};

  mult_div_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .op           (op),
    .abort        (abort),
    .mplier_lsb   (mplier_lsb),
    .rem_neg      (rem_neg),
    .divisor_zero (divisor_zero),
    .op_load      (op_load),
    .acc_clear    (acc_clear),
    .shift        (shift),
    .add_en       (add_en),
    .sub_en       (sub_en),
    .restore      (restore),
    .hi_load      (hi_load),
    .lo_load      (lo_load),
    .busy         (busy),
    .done         (done),
    .div0         (div0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (op_load) begin
      n_init    <= n_init + 1;
      n_shift   <= 0;
      n_sub     <= 0;
      n_hi      <= 0;
      n_lo      <= 0;
      n_done    <= 0;
      n_div0    <= 0;
      n_restore <= 0;
      n_rmis    <= 0;
      n_rbad    <= 0;
      add_mask  <= '0;
    end else begin
      if (shift) begin
        if (add_en && n_shift < 32) add_mask[n_shift] <= 1'b1;
        n_shift <= n_shift + 1;
      end
      if (sub_en) n_sub <= n_sub + 1;
      if (shift && sub_en) begin
        if (restore !== rem_neg) n_rmis <= n_rmis + 1;
        if (restore) n_restore <= n_restore + 1;
      end else if (restore) begin
        n_rbad <= n_rbad + 1;
      end
      if (hi_load) begin
        n_hi   <= n_hi + 1;
        hi_cyc <= cyc;
      end
      if (lo_load) n_lo <= n_lo + 1;
      if (done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
      if (div0) n_div0 <= n_div0 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at edge k; afterwards the DUT is in INIT.
  task automatic issue(input logic o);
    start = 1'b1;
    op    = o;
    tick();
    start = 1'b0;
    k     = cyc;
  endtask

  // Waits for done, then one more edge so the DONE cycle is in the stats.
  task automatic wait_done(input int limit, input bit tog);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (tog) rem_neg = ~rem_neg;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k1;

    // Reset state
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    tick();
    tick();
    chk("reset_hold_outs", 32'(outs), 32'd0);
    reset_n = 1'b1;

    // Multiply, lsb pattern 7: adds in RUN cycles 1-3 only
    rem_neg = 1'b1;
    issue(1'b0);
    chk("init_strobes", 32'({op_load, acc_clear, busy, shift}), 32'b1110);
    for (int i = 1; i <= WIDTH; i++) begin
      tick();
      mplier_lsb = (i <= 3);
    end
    mplier_lsb = 1'b0;
    wait_done(10, 1'b0);
    chk("mul_shift_cnt", 32'(n_shift), 32'(WIDTH));
    chk("mul_add_mask", add_mask, 32'h0000_0007);
    chk("mul_hi_lat", 32'(hi_cyc - k), 32'(WIDTH + 1));
    chk("mul_hilo_cnt", 32'(n_hi + n_lo), 32'd2);
    chk("mul_done_lat", 32'(done_cyc - k), 32'(WIDTH + 2));
    chk("mul_no_div0", 32'(n_div0), 32'd0);
    chk("mul_no_restore", 32'(n_rbad), 32'd0);
    chk("mul_idle", 32'(busy), 32'd0);
    rem_neg = 1'b0;
    $display("txn mult lsb=7 done_lat=%0d", done_cyc - k);

    // Divide by zero: INIT then DONE, no stepping or result load
    divisor_zero = 1'b1;
    issue(1'b1);
    chk("dz_init", 32'(op_load), 32'd1);
    wait_done(5, 1'b0);
    chk("dz_done_lat", 32'(done_cyc - k), 32'd1);
    chk("dz_div0_cnt", 32'(n_div0), 32'd1);
    chk("dz_no_step", 32'(n_shift + n_hi + n_lo), 32'd0);
    divisor_zero = 1'b0;
    $display("txn div-by-zero done_lat=%0d div0=%0d", done_cyc - k, n_div0);

    // Start during RUN is ignored
    base = n_init;
    issue(1'b0);
    for (int i = 0; i < 10; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("ign_init_cnt", 32'(n_init - base), 32'd1);
    chk("ign_done_cnt", 32'(n_done), 32'd1);
    chk("ign_done_lat", 32'(done_cyc - k), 32'(WIDTH + 2));
    chk("ign_idle", 32'(busy), 32'd0);
    $display("txn mult with stray start, inits=%0d", n_init - base);

    // Abort at RUN cycle 5
    issue(1'b0);
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("abort_shift_cnt", 32'(n_shift), 32'd5);
    chk("abort_no_done", 32'(n_done + n_hi + n_lo), 32'd0);
    issue(1'b0);
    wait_done(40, 1'b0);
    chk("post_abort_shift", 32'(n_shift), 32'(WIDTH));
    chk("post_abort_lat", 32'(done_cyc - k), 32'(WIDTH + 2));
    $display("txn abort then mult, shifts=%0d", n_shift);

    // Abort in IDLE wins over start
    base  = n_init;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    tick();
    chk("idle_abort_init", 32'(n_init - base), 32'd0);
    $display("txn start with abort in idle");

    // Asynchronous reset mid-RUN, then immediate restart
    rem_neg = 1'b1;
    issue(1'b1);
    tick();
    tick();
    tick();
    chk("pre_reset_shift", 32'({shift, sub_en, restore}), 32'b111);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs), 32'd0);
    #2;
    reset_n = 1'b1;
    rem_neg = 1'b0;
    start   = 1'b1;
    op      = 1'b0;
    tick();
    start = 1'b0;
    k     = cyc;
    chk("restart_init", 32'(op_load), 32'd1);
    wait_done(40, 1'b0);
    chk("restart_shift", 32'(n_shift), 32'(WIDTH));
    $display("txn reset mid-run then mult");

    // Back-to-back: multiply then divide with rem_neg toggling
    mplier_lsb = 1'b1;
    rem_neg    = 1'b1;
    issue(1'b0);
    wait_done(40, 1'b0);
    chk("b2b_mul_adds", add_mask, 32'hFFFF_FFFF);
    chk("b2b_mul_nosub", 32'(n_sub + n_rbad), 32'd0);
    k1 = done_cyc;
    issue(1'b1);
    chk("b2b_accept", 32'(k - k1), 32'd2);
    wait_done(40, 1'b1);
    chk("b2b_div_sub", 32'(n_sub), 32'(WIDTH));
    chk("b2b_div_noadd", add_mask, 32'd0);
    chk("b2b_restore_mis", 32'(n_rmis), 32'd0);
    chk("b2b_restore_out", 32'(n_rbad), 32'd0);
    chk("b2b_restore_seen", 32'(n_restore > 0), 32'd1);
    chk("b2b_div_lat", 32'(done_cyc - k), 32'(WIDTH + 2));
    chk("b2b_div_nodiv0", 32'(n_div0), 32'd0);
    mplier_lsb = 1'b0;
    rem_neg    = 1'b0;
    $display("txn back-to-back mult/div, restores=%0d", n_restore);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
